clock_set_ctrl: RTL and testbench

//  Button-driven set controller for the digital clock. Sequences the user

---
 rtl/clock_set_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Button-driven hour/minute set controller for the digital clock.
// Walks the user through an hours then minutes edit of either the current
// time or the alarm time, then presents the BCD digits and pulses the
// matching active-low load strobe for one cycle. Keeps a shadow of the
// alarm time because the clock cannot be read back.
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       mode_btn_i,
    input  logic       inc_btn_i,
    input  logic       dec_btn_i,
    input  logic       sel_alarm_i,
    input  logic [1:0] cur_h_i1,
    input  logic [3:0] cur_h_i2,
    input  logic [3:0] cur_m_i1,
    input  logic [3:0] cur_m_i2,
    output logic [1:0] h_o1,
    output logic [3:0] h_o2,
    output logic [3:0] m_o1,
    output logic [3:0] m_o2,
    output logic       load_time_n_o,
    output logic       load_alarm_n_o,
    output logic       editing_o,
    output logic [1:0] field_o
);

    localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    localparam logic [1:0] FieldNone = 2'b00;
    localparam logic [1:0] FieldHour = 2'b01;
    localparam logic [1:0] FieldMin  = 2'b10;

    typedef enum logic [1:0] {StIdle, StEditH, StEditM, StCommit} state_e;

    state_e            state_q;
    logic              target_q;  // 1 = alarm, 0 = time
    logic              mode_q, inc_q, dec_q;
    logic [1:0]        h1_q;
    logic [3:0]        h2_q, m1_q, m2_q;
    logic [1:0]        sh_h1_q;
    logic [3:0]        sh_h2_q, sh_m1_q, sh_m2_q;
    logic [TimerW-1:0] timer_q;
    logic              load_time_n_q, load_alarm_n_q, editing_q;
    logic [1:0]        field_q;

    logic       mode_press, inc_press, dec_press, any_press, do_inc, do_dec;
    logic [1:0] pre_h1;
    logic [3:0] pre_h2, pre_m1, pre_m2;
    logic       pre_valid;
    logic [1:0] h_inc1, h_dec1;
    logic [3:0] h_inc2, h_dec2, m_inc1, m_inc2, m_dec1, m_dec2;

    // Edge detection, preload selection/sanitising and BCD step results.
    always_comb begin
        mode_press = mode_btn_i & ~mode_q;
        inc_press  = inc_btn_i & ~inc_q;
        dec_press  = dec_btn_i & ~dec_q;
        any_press  = mode_press | inc_press | dec_press;
        // Simultaneous inc and dec cancel each other.
        do_inc     = inc_press & ~dec_press;
        do_dec     = dec_press & ~inc_press;

        if (sel_alarm_i) begin
            pre_h1 = sh_h1_q;
            pre_h2 = sh_h2_q;
            pre_m1 = sh_m1_q;
            pre_m2 = sh_m2_q;
        end else begin
            pre_h1 = cur_h_i1;
            pre_h2 = cur_h_i2;
            pre_m1 = cur_m_i1;
            pre_m2 = cur_m_i2;
        end
        pre_valid = (pre_h2 <= 4'd9) && (pre_m1 <= 4'd5) && (pre_m2 <= 4'd9) &&
                    ((pre_h1 < 2'd2) || ((pre_h1 == 2'd2) && (pre_h2 <= 4'd3)));

        if (h1_q == 2'd2 && h2_q == 4'd3) begin
            h_inc1 = 2'd0;
            h_inc2 = 4'd0;
        end else if (h2_q >= 4'd9) begin
            h_inc1 = h1_q + 2'd1;
            h_inc2 = 4'd0;
        end else begin
            h_inc1 = h1_q;
            h_inc2 = h2_q + 4'd1;
        end

        if (h1_q == 2'd0 && h2_q == 4'd0) begin
            h_dec1 = 2'd2;
            h_dec2 = 4'd3;
        end else if (h2_q == 4'd0) begin
            h_dec1 = h1_q - 2'd1;
            h_dec2 = 4'd9;
        end else begin
            h_dec1 = h1_q;
            h_dec2 = h2_q - 4'd1;
        end

        if (m1_q == 4'd5 && m2_q == 4'd9) begin
            m_inc1 = 4'd0;
            m_inc2 = 4'd0;
        end else if (m2_q >= 4'd9) begin
            m_inc1 = m1_q + 4'd1;
            m_inc2 = 4'd0;
        end else begin
            m_inc1 = m1_q;
            m_inc2 = m2_q + 4'd1;
        end

        if (m1_q == 4'd0 && m2_q == 4'd0) begin
            m_dec1 = 4'd5;
            m_dec2 = 4'd9;
        end else if (m2_q == 4'd0) begin
            m_dec1 = m1_q - 4'd1;
            m_dec2 = 4'd9;
        end else begin
            m_dec1 = m1_q;
            m_dec2 = m2_q - 4'd1;
        end
    end

    // Edit FSM with registered digits, strobes and status outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            target_q       <= 1'b0;
            mode_q         <= 1'b0;
            inc_q          <= 1'b0;
            dec_q          <= 1'b0;
            h1_q           <= 2'd0;
            h2_q           <= 4'd0;
            m1_q           <= 4'd0;
            m2_q           <= 4'd0;
            sh_h1_q        <= 2'd0;
            sh_h2_q        <= 4'd0;
            sh_m1_q        <= 4'd0;
            sh_m2_q        <= 4'd0;
            timer_q        <= '0;
            load_time_n_q  <= 1'b1;
            load_alarm_n_q <= 1'b1;
            editing_q      <= 1'b0;
            field_q        <= FieldNone;
        end else begin
            mode_q         <= mode_btn_i;
            inc_q          <= inc_btn_i;
            dec_q          <= dec_btn_i;
            load_time_n_q  <= 1'b1;
            load_alarm_n_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (mode_press) begin
                        state_q   <= StEditH;
                        target_q  <= sel_alarm_i;
                        timer_q   <= '0;
                        editing_q <= 1'b1;
                        field_q   <= FieldHour;
                        h1_q      <= pre_valid ? pre_h1 : 2'd0;
                        h2_q      <= pre_valid ? pre_h2 : 4'd0;
                        m1_q      <= pre_valid ? pre_m1 : 4'd0;
                        m2_q      <= pre_valid ? pre_m2 : 4'd0;
                    end
                end

                StEditH, StEditM: begin
                    if (any_press) begin
                        timer_q <= '0;
                    end else if (timer_q == TimerLast) begin
                        // Abandon the edit: no strobe, shadow untouched.
                        state_q   <= StIdle;
                        timer_q   <= '0;
                        editing_q <= 1'b0;
                        field_q   <= FieldNone;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end

                    if (mode_press) begin
                        if (state_q == StEditH) begin
                            state_q <= StEditM;
                            field_q <= FieldMin;
                        end else begin
                            state_q   <= StCommit;
                            editing_q <= 1'b0;
                            field_q   <= FieldNone;
                            if (target_q) begin
                                load_alarm_n_q <= 1'b0;
                                sh_h1_q        <= h1_q;
                                sh_h2_q        <= h2_q;
                                sh_m1_q        <= m1_q;
                                sh_m2_q        <= m2_q;
                            end else begin
                                load_time_n_q <= 1'b0;
                            end
                        end
                    end else if (do_inc) begin
                        if (state_q == StEditH) begin
                            h1_q <= h_inc1;
                            h2_q <= h_inc2;
                        end else begin
                            m1_q <= m_inc1;
                            m2_q <= m_inc2;
                        end
                    end else if (do_dec) begin
                        if (state_q == StEditH) begin
                            h1_q <= h_dec1;
                            h2_q <= h_dec2;
                        end else begin
                            m1_q <= m_dec1;
                            m2_q <= m_dec2;
                        end
                    end
                end

                StCommit: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign h_o1           = h1_q;
    assign h_o2           = h2_q;
    assign m_o1           = m1_q;
    assign m_o2           = m2_q;
    assign load_time_n_o  = load_time_n_q;
    assign load_alarm_n_o = load_alarm_n_q;
    assign editing_o      = editing_q;
    assign field_o        = field_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: integer-level reference model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_clock_set_ctrl;

    localparam int TIMEOUT = 30;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       mode_btn_i = 1'b0, inc_btn_i = 1'b0, dec_btn_i = 1'b0;
    logic       sel_alarm_i = 1'b0;
    logic [1:0] cur_h_i1 = 2'd0;
    logic [3:0] cur_h_i2 = 4'd0, cur_m_i1 = 4'd0, cur_m_i2 = 4'd0;
    logic [1:0] h_o1;
    logic [3:0] h_o2, m_o1, m_o2;
    logic       load_time_n_o, load_alarm_n_o, editing_o;
    logic [1:0] field_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_edit = 0, n_tlow = 0, n_alow = 0;
    bit chk_en = 1'b0;

    clock_set_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .mode_btn_i    (mode_btn_i),
        .inc_btn_i     (inc_btn_i),
        .dec_btn_i     (dec_btn_i),
        .sel_alarm_i   (sel_alarm_i),
        .cur_h_i1      (cur_h_i1),
        .cur_h_i2      (cur_h_i2),
        .cur_m_i1      (cur_m_i1),
        .cur_m_i2      (cur_m_i2),
        .h_o1          (h_o1),
        .h_o2          (h_o2),
        .m_o1          (m_o1),
        .m_o2          (m_o2),
        .load_time_n_o (load_time_n_o),
        .load_alarm_n_o(load_alarm_n_o),
        .editing_o     (editing_o),
        .field_o       (field_o)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 hours, 2 minutes, 3 commit; times as integers.
    int m_st = 0, m_h = 0, m_m = 0, m_sh_h = 0, m_sh_m = 0, m_tmr = 0;
    bit m_tgt = 1'b0, m_pm = 1'b0, m_pi = 1'b0, m_pd = 1'b0;
    int nx_st, nx_h, nx_m, nx_sh_h, nx_sh_m, nx_tmr, ch, cm;
    bit nx_tgt, nx_pm, nx_pi, nx_pd, mp, ip, dp, ok;

    always_comb begin
        nx_st = m_st; nx_h = m_h; nx_m = m_m; nx_sh_h = m_sh_h; nx_sh_m = m_sh_m;
        nx_tmr = m_tmr; nx_tgt = m_tgt;
        nx_pm = mode_btn_i; nx_pi = inc_btn_i; nx_pd = dec_btn_i;
        mp = mode_btn_i && !m_pm;
        ip = inc_btn_i && !m_pi;
        dp = dec_btn_i && !m_pd;
        ch = int'(cur_h_i1) * 10 + int'(cur_h_i2);
        cm = int'(cur_m_i1) * 10 + int'(cur_m_i2);
        ok = (cur_h_i2 <= 9) && (cur_m_i1 <= 5) && (cur_m_i2 <= 9) && (ch <= 23);
        if (reset_i) begin
            nx_st = 0; nx_h = 0; nx_m = 0; nx_sh_h = 0; nx_sh_m = 0; nx_tmr = 0;
            nx_tgt = 1'b0; nx_pm = 1'b0; nx_pi = 1'b0; nx_pd = 1'b0;
        end else if (m_st == 0) begin
            if (mp) begin
                nx_st = 1; nx_tgt = sel_alarm_i; nx_tmr = 0;
                if (sel_alarm_i) begin
                    nx_h = m_sh_h; nx_m = m_sh_m;
                end else begin
                    nx_h = ok ? ch : 0; nx_m = ok ? cm : 0;
                end
            end
        end else if (m_st == 1 || m_st == 2) begin
            if (mp || ip || dp) nx_tmr = 0;
            else if (m_tmr == TIMEOUT - 1) begin
                nx_st = 0; nx_tmr = 0;
            end else nx_tmr = m_tmr + 1;
            if (mp) begin
                nx_st = m_st + 1;
                if (m_st == 2 && m_tgt) begin
                    nx_sh_h = m_h; nx_sh_m = m_m;
                end
            end else if (ip && !dp) begin
                if (m_st == 1) nx_h = (m_h + 1) % 24; else nx_m = (m_m + 1) % 60;
            end else if (dp && !ip) begin
                if (m_st == 1) nx_h = (m_h + 23) % 24; else nx_m = (m_m + 59) % 60;
            end
        end else begin
            nx_st = 0;
        end
    end

    // Advance the model on the same edge as the DUT.
    always @(posedge clk) begin
        m_st <= nx_st; m_h <= nx_h; m_m <= nx_m; m_sh_h <= nx_sh_h; m_sh_m <= nx_sh_m;
        m_tmr <= nx_tmr; m_tgt <= nx_tgt; m_pm <= nx_pm; m_pi <= nx_pi; m_pd <= nx_pd;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("h_o1", int'(h_o1), m_h / 10);
        chk("h_o2", int'(h_o2), m_h % 10);
        chk("m_o1", int'(m_o1), m_m / 10);
        chk("m_o2", int'(m_o2), m_m % 10);
        chk("load_time_n_o", int'(load_time_n_o), (m_st == 3 && !m_tgt) ? 0 : 1);
        chk("load_alarm_n_o", int'(load_alarm_n_o), (m_st == 3 && m_tgt) ? 0 : 1);
        chk("editing_o", int'(editing_o), (m_st == 1 || m_st == 2) ? 1 : 0);
        chk("field_o", int'(field_o), (m_st == 1) ? 1 : ((m_st == 2) ? 2 : 0));
        chk("both_strobes_low", int'(!load_time_n_o && !load_alarm_n_o), 0);
        if (editing_o === 1'b1) n_edit++;
        if (load_time_n_o === 1'b0) n_tlow++;
        if (load_alarm_n_o === 1'b0) n_alow++;
    endtask

    // Compare on the falling edge, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int which);
        if (which == 0) mode_btn_i = 1'b1;
        else if (which == 1) inc_btn_i = 1'b1;
        else dec_btn_i = 1'b1;
        tick();
        mode_btn_i = 1'b0; inc_btn_i = 1'b0; dec_btn_i = 1'b0;
        tick();
    endtask

    task automatic set_cur(input int h, input int m);
        cur_h_i1 = 2'(h / 10); cur_h_i2 = 4'(h % 10);
        cur_m_i1 = 4'(m / 10); cur_m_i2 = 4'(m % 10);
    endtask

    task automatic chk_time(input string name, input int h, input int m);
        chk({name, ".h1"}, int'(h_o1), h / 10);
        chk({name, ".h2"}, int'(h_o2), h % 10);
        chk({name, ".m1"}, int'(m_o1), m / 10);
        chk({name, ".m2"}, int'(m_o2), m % 10);
    endtask

    int t0, a0, e0;

    initial begin
        @(posedge clk); #1;
        tick();
        chk_en = 1'b1;
        reset_i = 1'b0;
        tick();
        chk_time("reset", 0, 0);
        chk("reset.load_time_n", int'(load_time_n_o), 1);
        chk("reset.field", int'(field_o), 0);

        // 1: time edit 12:34 -> 13:36
        set_cur(12, 34); sel_alarm_i = 1'b0;
        t0 = n_tlow; a0 = n_alow;
        press(0); press(1); press(0); press(1); press(1); press(0);
        tick(); tick();
        chk_time("s1", 13, 36);
        chk("s1.time_strobe_cycles", n_tlow - t0, 1);
        chk("s1.alarm_strobe_cycles", n_alow - a0, 0);

        // 2: alarm edit to 07:00 then preload from shadow
        sel_alarm_i = 1'b1;
        t0 = n_tlow; a0 = n_alow;
        press(0);
        repeat (7) press(1);
        press(0); press(0);
        tick();
        chk_time("s2.commit", 7, 0);
        chk("s2.alarm_strobe_cycles", n_alow - a0, 1);
        chk("s2.time_strobe_cycles", n_tlow - t0, 0);
        press(0);
        chk_time("s2.preload", 7, 0);
        chk("s2.field", int'(field_o), 1);
        repeat (TIMEOUT + 2) tick();
        chk("s2.editing_after_timeout", int'(editing_o), 0);

        // 3: wrap boundaries
        sel_alarm_i = 1'b0;
        set_cur(23, 59);
        press(0);
        press(1); chk("s3.h23_inc.h2", int'(h_o2), 0); chk("s3.h23_inc.h1", int'(h_o1), 0);
        press(2); chk("s3.h00_dec.h2", int'(h_o2), 3); chk("s3.h00_dec.h1", int'(h_o1), 2);
        press(0);
        press(1); chk("s3.m59_inc.m1", int'(m_o1), 0); chk("s3.m59_inc.m2", int'(m_o2), 0);
        press(2); chk("s3.m00_dec.m1", int'(m_o1), 5); chk("s3.m00_dec.m2", int'(m_o2), 9);
        press(0);
        set_cur(10, 9);
        press(0); press(0);
        press(1); chk("s3.m09_inc.m1", int'(m_o1), 1); chk("s3.m09_inc.m2", int'(m_o2), 0);
        press(2); chk("s3.m10_dec.m1", int'(m_o1), 0); chk("s3.m10_dec.m2", int'(m_o2), 9);
        repeat (TIMEOUT + 2) tick();

        // 4: timeout, then a press at TIMEOUT-2 restarts the count
        t0 = n_tlow; a0 = n_alow; e0 = n_edit;
        mode_btn_i = 1'b1; tick(); mode_btn_i = 1'b0;
        repeat (TIMEOUT + 5) tick();
        chk("s4.edit_cycles", n_edit - e0, TIMEOUT);
        chk("s4.editing", int'(editing_o), 0);
        e0 = n_edit;
        mode_btn_i = 1'b1; tick(); mode_btn_i = 1'b0;
        repeat (TIMEOUT - 3) tick();
        inc_btn_i = 1'b1; tick(); inc_btn_i = 1'b0;
        repeat (TIMEOUT + 5) tick();
        chk("s4.restart_edit_cycles", n_edit - e0, 2 * TIMEOUT - 2);
        chk("s4.no_strobe", (n_tlow - t0) + (n_alow - a0), 0);

        // 5: sanitised preload, cancelled inc+dec, held button
        cur_h_i1 = 2'd2; cur_h_i2 = 4'd9; cur_m_i1 = 4'd3; cur_m_i2 = 4'd4;
        press(0);
        chk_time("s5.sanitised", 0, 0);
        inc_btn_i = 1'b1; dec_btn_i = 1'b1; tick();
        inc_btn_i = 1'b0; dec_btn_i = 1'b0; tick();
        chk("s5.incdec.h2", int'(h_o2), 0);
        chk("s5.incdec.h1", int'(h_o1), 0);
        inc_btn_i = 1'b1; repeat (10) tick(); inc_btn_i = 1'b0; tick();
        chk("s5.held.h2", int'(h_o2), 1);
        press(0);
        chk("s5.field_min", int'(field_o), 2);

        // 6: reset in the minutes field clears everything including the shadow
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        chk_time("s6.reset", 0, 0);
        chk("s6.editing", int'(editing_o), 0);
        chk("s6.field", int'(field_o), 0);
        chk("s6.load_time_n", int'(load_time_n_o), 1);
        chk("s6.load_alarm_n", int'(load_alarm_n_o), 1);
        tick();
        sel_alarm_i = 1'b1;
        press(0);
        chk_time("s6.shadow", 0, 0);
        repeat (TIMEOUT + 2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
